// File: rtl/top.sv
// Direct-form F(2x2,3x3) convolution engine: scan-loaded data/weight memories, channel
// accumulation, and two scan-readable output memories for even and odd output channels.
module top #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORD_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic [3:0]        total_id,
  input  logic [7:0]        total_od,
  input  logic [8:0]        total_width,
  input  logic [8:0]        total_height,
  input  logic              total_size_type,
  input  logic              wen,
  input  logic              input_mem_scan_mode,
  input  logic [1:0]        output_mem_scan_mode,
  input  logic [7:0]        scan_addr,
  input  logic [WORD_W-1:0] data_mem_scan_in,
  input  logic [WORD_W-1:0] weight_mem_scan_in,
  output logic [WORD_W-1:0] output_mem1_scan_out,
  output logic [WORD_W-1:0] output_mem2_scan_out,
  output logic              conv_completed
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [WORD_W-1:0] data_mem   [Depth];
  logic [WORD_W-1:0] weight_mem [Depth];
  logic [WORD_W-1:0] out_mem1   [Depth];
  logic [WORD_W-1:0] out_mem2   [Depth];

  logic [3:0]  id_eff;
  logic [7:0]  od_eff;
  logic [8:0]  width_eff, height_eff;
  logic [17:0] area;
  logic [13:0] wpc;

  assign id_eff     = (total_id == 4'd0) ? 4'd1 : total_id;
  assign od_eff     = (total_od == 8'd0) ? 8'd1 : total_od;
  assign width_eff  = total_size_type ? total_width  : 9'd8;
  assign height_eff = total_size_type ? total_height : 9'd8;
  assign area       = 18'(width_eff) * 18'(height_eff);
  assign wpc        = area[17:4];

  logic unused_ok;
  assign unused_ok = ^{mem_clk, scan_addr[7], area[3:0]};

  logic [7:0]  o_q;
  logic [13:0] w_q;
  logic [3:0]  c_q;
  logic        last_c, last_w, last_o, issue;
  logic [ADDR_W-1:0] d_addr, k_addr, o_addr, scan_idx;

  assign last_c   = (c_q == id_eff - 4'd1);
  assign last_w   = (w_q == wpc - 14'd1);
  assign last_o   = (o_q == od_eff - 8'd1);
  // Only the low address bits matter, so the products are formed at address width.
  assign d_addr   = ADDR_W'(c_q) * ADDR_W'(wpc) + ADDR_W'(w_q);
  assign k_addr   = ADDR_W'(o_q) * ADDR_W'(id_eff) + ADDR_W'(c_q);
  assign o_addr   = ADDR_W'(o_q >> 1) * ADDR_W'(wpc) + ADDR_W'(w_q);
  assign scan_idx = scan_addr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (wen && !input_mem_scan_mode) state_d = (wpc == 14'd0) ? StDone : StRun;
      StRun:   if (wen && last_c && last_w && last_o) state_d = StDrain;
      StDrain: if (wen) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue          = (state_q == StRun) && wen;
    conv_completed = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
      w_q <= '0;
      c_q <= '0;
    end else if (issue) begin
      if (!last_c) begin
        c_q <= c_q + 4'd1;
      end else begin
        c_q <= '0;
        if (!last_w) begin
          w_q <= w_q + 14'd1;
        end else begin
          w_q <= '0;
          o_q <= o_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (input_mem_scan_mode) begin
      data_mem[scan_idx]   <= data_mem_scan_in;
      weight_mem[scan_idx] <= weight_mem_scan_in;
    end
  end

  // Read stage: synchronous memory read plus the loop position that goes with it.
  logic              valid_q, first_q, last_q, odd_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [WORD_W-1:0] data_q;
  logic [71:0]       kern_q;

  always_ff @(posedge clk) begin
    if (reset)    valid_q <= 1'b0;
    else if (wen) valid_q <= issue;
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      data_q  <= data_mem[d_addr];
      kern_q  <= weight_mem[k_addr][71:0];
      first_q <= (c_q == 4'd0);
      last_q  <= last_c;
      odd_q   <= o_q[0];
      waddr_q <= o_addr;
    end
  end

  function automatic logic [WORD_W-1:0] conv_word(input logic [WORD_W-1:0] d,
                                                  input logic [71:0] k);
    logic [31:0]        s;
    logic signed [7:0]  px, kv;
    logic signed [15:0] p;
    conv_word = '0;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          s = '0;
          for (int u = 0; u < 3; u++) begin
            for (int v = 0; v < 3; v++) begin
              px = d[128*t + 8*(4*(i+u) + (j+v)) +: 8];
              kv = k[8*(3*u + v) +: 8];
              p  = 16'(px) * 16'(kv);
              s  = s + {{16{p[15]}}, p};
            end
          end
          conv_word[128*t + 32*(2*i + j) +: 32] = s;
        end
      end
    end
  endfunction

  logic [WORD_W-1:0] conv, acc_d, acc_q;
  assign conv = conv_word(data_q, kern_q);

  always_comb begin
    acc_d = conv;
    if (!first_q) begin
      for (int l = 0; l < 16; l++) acc_d[32*l +: 32] = acc_q[32*l +: 32] + conv[32*l +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                acc_q <= '0;
    else if (valid_q && wen)  acc_q <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && wen && valid_q && last_q && output_mem_scan_mode == 2'b01) begin
      if (odd_q) out_mem2[waddr_q] <= acc_d;
      else       out_mem1[waddr_q] <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      output_mem1_scan_out <= '0;
      output_mem2_scan_out <= '0;
    end else if (output_mem_scan_mode == 2'b11) begin
      output_mem1_scan_out <= out_mem1[scan_idx];
      output_mem2_scan_out <= out_mem2[scan_idx];
    end
  end

endmodule

// File: tb/tb_top.sv
// Randomised bench for the convolution top: a per-pixel reference model tracks the
// expected contents of both output memories across runs.
module tb_top;
  logic         clk = 1'b0;
  logic         reset, mem_clk, total_size_type, wen, input_mem_scan_mode;
  logic [3:0]   total_id;
  logic [7:0]   total_od;
  logic [8:0]   total_width, total_height;
  logic [1:0]   output_mem_scan_mode;
  logic [7:0]   scan_addr;
  logic [511:0] data_in, weight_in, out1, out2;
  logic         conv_completed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] dmem [128];
  logic [511:0] wmem [128];
  logic [511:0] exp1 [128];
  logic [511:0] exp2 [128];
  bit           v1   [128];
  bit           v2   [128];

  always #5 clk = ~clk;

  top dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_clk              (mem_clk),
    .total_id             (total_id),
    .total_od             (total_od),
    .total_width          (total_width),
    .total_height         (total_height),
    .total_size_type      (total_size_type),
    .wen                  (wen),
    .input_mem_scan_mode  (input_mem_scan_mode),
    .output_mem_scan_mode (output_mem_scan_mode),
    .scan_addr            (scan_addr),
    .data_mem_scan_in     (data_in),
    .weight_mem_scan_in   (weight_in),
    .output_mem1_scan_out (out1),
    .output_mem2_scan_out (out2),
    .conv_completed       (conv_completed)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sb(input logic [511:0] wd, input int idx);
    return int'($signed(wd[8*idx +: 8]));
  endfunction

  // kind: 0 ones, 1 ramp pixels with centre tap 2, 2 all -128, 3 all 127, 4 random
  task automatic fill(input int kind);
    for (int a = 0; a < 128; a++) begin
      logic [511:0] d, k;
      d = rand512();
      k = rand512();
      case (kind)
        0: begin d = {64{8'h01}}; k[71:0] = {9{8'h01}}; end
        1: begin
          for (int t = 0; t < 4; t++)
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++) d[128*t + 8*(4*r + c) +: 8] = 8'(4*r + c);
          k[71:0] = '0;
          k[39:32] = 8'd2;
        end
        2: begin d = {64{8'h80}}; k[71:0] = {9{8'h80}}; end
        3: begin d = {64{8'h7f}}; k[71:0] = {9{8'h7f}}; end
        default: ;
      endcase
      dmem[a] = d;
      wmem[a] = k;
    end
  endtask

  task automatic load_all();
    reset = 1'b1;
    input_mem_scan_mode = 1'b1;
    for (int a = 0; a < 128; a++) begin
      scan_addr = {1'($urandom), 7'(a)};
      data_in   = dmem[a];
      weight_in = wmem[a];
      @(posedge clk); #1;
    end
    input_mem_scan_mode = 1'b0;
  endtask

  // Reference: each output pixel computed straight from the convolution definition.
  task automatic model_run(input int ide, input int ode, input int wpc);
    for (int o = 0; o < ode; o++) begin
      for (int w = 0; w < wpc; w++) begin
        logic [511:0] word;
        int addr;
        word = '0;
        for (int t = 0; t < 4; t++)
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
              logic [31:0] acc;
              acc = '0;
              for (int c = 0; c < ide; c++) begin
                int da, wa;
                da = (c*wpc + w) % 128;
                wa = (o*ide + c) % 128;
                for (int u = 0; u < 3; u++)
                  for (int v = 0; v < 3; v++)
                    acc = acc + 32'(sb(dmem[da], 16*t + 4*(i+u) + (j+v)) * sb(wmem[wa], 3*u + v));
              end
              word[128*t + 32*(2*i + j) +: 32] = acc;
            end
        addr = ((o/2)*wpc + w) % 128;
        if (o % 2 == 0) begin exp1[addr] = word; v1[addr] = 1'b1; end
        else            begin exp2[addr] = word; v2[addr] = 1'b1; end
      end
    end
  endtask

  task automatic read_addr(input int a);
    output_mem_scan_mode = 2'b11;
    scan_addr = {1'($urandom), 7'(a)};
    @(posedge clk); #1;
  endtask

  task automatic scan_check();
    logic [511:0] held1;
    held1 = out1;
    for (int a = 0; a < 128; a++) begin
      if (v1[a] || v2[a]) begin
        read_addr(a);
        held1 = out1;
        if (v1[a]) begin
          n_checks++;
          if (out1 !== exp1[a]) begin
            n_fail++;
            $display("FAIL mem1[%0d]: got %h want %h", a, out1, exp1[a]);
          end
        end
        if (v2[a]) begin
          n_checks++;
          if (out2 !== exp2[a]) begin
            n_fail++;
            $display("FAIL mem2[%0d]: got %h want %h", a, out2, exp2[a]);
          end
        end
      end
    end
    output_mem_scan_mode = 2'b10;
    scan_addr = 8'($urandom);
    @(posedge clk); #1;
    n_checks++;
    if (out1 !== held1) begin
      n_fail++;
      $display("FAIL scan_hold: got %h want %h", out1, held1);
    end
    output_mem_scan_mode = 2'b00;
  endtask

  task automatic run_conv(input int id_in, input int od_in, input int st, input int wd,
                          input int ht, input int pause_at, input int reset_at,
                          output int cyc);
    int ide, ode, we, he, wpc, nwork, limit, slack;
    bit done;
    ide   = (id_in == 0) ? 1 : id_in;
    ode   = (od_in == 0) ? 1 : od_in;
    we    = st ? wd : 8;
    he    = st ? ht : 8;
    wpc   = (we * he) / 16;
    nwork = ode * ide * wpc;
    slack = (pause_at >= 0) ? 14 : 4;
    limit = nwork + 60;
    total_id = 4'(id_in);
    total_od = 8'(od_in);
    total_size_type = 1'(st);
    total_width  = 9'(wd);
    total_height = 9'(ht);
    output_mem_scan_mode = 2'b01;
    input_mem_scan_mode  = 1'b0;
    wen   = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < limit) begin
      if (pause_at >= 0 && cyc == pause_at)      wen = 1'b0;
      if (pause_at >= 0 && cyc == pause_at + 10) wen = 1'b1;
      if (reset_at >= 0 && cyc == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (conv_completed !== 1'b0 || out1 !== '0 || out2 !== '0) begin
          n_fail++;
          $display("FAIL mid_reset: got done=%b out1=%h want done=0 out1=0", conv_completed, out1);
        end
        reset = 1'b0;
        cyc = 0;
        reset_at = -1;
      end
      @(posedge clk); #1;
      cyc++;
      done = conv_completed;
    end
    n_checks++;
    if (!done || cyc > nwork + slack) begin
      n_fail++;
      $display("FAIL latency: got done=%b after %0d cycles want done within %0d", done, cyc,
               nwork + slack);
    end
    model_run(ide, ode, wpc);
    scan_check();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (conv_completed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", conv_completed);
    end
    n_checks++;
    if (out1 !== '0) begin n_fail++; $display("FAIL reset_out1: got %h want 0", out1); end
    n_checks++;
    if (out2 !== '0) begin n_fail++; $display("FAIL reset_out2: got %h want 0", out2); end
  endtask

  task automatic test_neg();
    int cyc;
    fill(2); load_all();
    run_conv(2, 2, 1, 24, 24, -1, -1, cyc);
    read_addr(35);
    n_checks++;
    if (out1[31:0] !== 32'd294912 || out2[31:0] !== 32'd294912) begin
      n_fail++;
      $display("FAIL neg_lane: got %0d/%0d want 294912", out1[31:0], out2[31:0]);
    end
  endtask

  task automatic test_ones();
    int cyc;
    fill(0); load_all();
    run_conv(1, 1, 1, 24, 24, -1, -1, cyc);
    n_checks++;
    if (cyc > 40) begin n_fail++; $display("FAIL ones_latency: got %0d want <=40", cyc); end
    read_addr(0);
    n_checks++;
    if (out1[31:0] !== 32'd9) begin
      n_fail++;
      $display("FAIL ones_lane: got %0d want 9", out1[31:0]);
    end
  endtask

  task automatic test_center();
    int cyc;
    fill(1); load_all();
    run_conv(0, 1, 0, 0, 0, -1, -1, cyc);
    read_addr(3);
    n_checks++;
    if (out1[127:0] !== {32'd20, 32'd18, 32'd12, 32'd10}) begin
      n_fail++;
      $display("FAIL center_tile: got %h want 14_12_0c_0a", out1[127:0]);
    end
  endtask

  task automatic test_max();
    int cyc;
    fill(3); load_all();
    run_conv(15, 1, 0, 100, 100, -1, -1, cyc);
    read_addr(3);
    n_checks++;
    if (out1[511:480] !== 32'd2177415) begin
      n_fail++;
      $display("FAIL max_lane: got %0d want 2177415", out1[511:480]);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 3; n++) begin
      fill(4); load_all();
      run_conv($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 1),
               2 * $urandom_range(2, 16), 2 * $urandom_range(2, 16), -1, -1, cyc);
    end
  endtask

  task automatic test_wen_pause();
    int c0, c1;
    fill(4); load_all();
    run_conv(2, 3, 1, 16, 16, -1, -1, c0);
    run_conv(2, 3, 1, 16, 16, 20, -1, c1);
    n_checks++;
    if (c1 !== c0 + 10) begin
      n_fail++;
      $display("FAIL wen_pause: got %0d cycles want %0d", c1, c0 + 10);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill(4); load_all();
    run_conv(1, 2, 1, 16, 16, -1, 15, cyc);
  endtask

  initial begin
    reset = 1'b1; mem_clk = 1'b0; wen = 1'b0; input_mem_scan_mode = 1'b0;
    output_mem_scan_mode = 2'b00; scan_addr = '0; data_in = '0; weight_in = '0;
    total_id = 4'd1; total_od = 8'd1; total_width = 9'd8; total_height = 9'd8;
    total_size_type = 1'b0;
    for (int a = 0; a < 128; a++) begin v1[a] = 1'b0; v2[a] = 1'b0; end
    test_reset();
    test_neg();
    test_ones();
    test_center();
    test_max();
    test_random();
    test_wen_pause();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
